// File: rtl/vga_timing_pkg.sv
// rtl/vga_timing_pkg.sv - default 640x480@60 timing constants, blanking sentinels and sync window helper
package vga_timing_pkg;

   localparam int DEF_CLK_DIV   = 4;
   localparam int DEF_H_VISIBLE = 640;
   localparam int DEF_H_FRONT   = 16;
   localparam int DEF_H_SYNC    = 96;
   localparam int DEF_H_BACK    = 48;
   localparam int DEF_V_VISIBLE = 480;
   localparam int DEF_V_FRONT   = 10;
   localparam int DEF_V_SYNC    = 2;
   localparam int DEF_V_BACK    = 33;

   localparam int H_TOTAL = DEF_H_VISIBLE + DEF_H_FRONT + DEF_H_SYNC + DEF_H_BACK;
   localparam int V_TOTAL = DEF_V_VISIBLE + DEF_V_FRONT + DEF_V_SYNC + DEF_V_BACK;

   localparam int HS_START = DEF_H_VISIBLE + DEF_H_FRONT;
   localparam int HS_END   = HS_START + DEF_H_SYNC;
   localparam int VS_START = DEF_V_VISIBLE + DEF_V_FRONT;
   localparam int VS_END   = VS_START + DEF_V_SYNC;

   localparam logic [9:0] COL_BLANK = 10'd1023;
   localparam logic [8:0] ROW_BLANK = 9'd511;

   // Half-open window test [lo, hi) on a 10-bit counter value.
   function automatic logic in_window(input logic [9:0] v, input logic [9:0] lo,
                                      input logic [9:0] hi);
      return (v >= lo) && (v < hi);
   endfunction

endpackage

// File: rtl/pix_tick_gen.sv
// rtl/pix_tick_gen.sv - CLK_DIV prescaler producing the one-clk pixel strobe
module pix_tick_gen
   import vga_timing_pkg::*;
#(
   parameter int CLK_DIV = DEF_CLK_DIV
) (
   input  logic clk,
   input  logic rst,
   output logic pix_en
);

   localparam int W = (CLK_DIV > 2) ? $clog2(CLK_DIV) : 1;
   localparam logic [W-1:0] LAST = W'(CLK_DIV - 1);

   logic [W-1:0] presc;

   always_ff @(posedge clk) begin
      if (rst) begin
         presc <= '0;
      end else if (presc == LAST) begin
         presc <= '0;
      end else begin
         presc <= presc + 1'b1;
      end
   end

   // Decoded straight from the prescaler register, so it is low throughout reset.
   assign pix_en = (presc == LAST);

endmodule

// File: rtl/vga_timing_gen.sv
// rtl/vga_timing_gen.sv - VGA raster counters with registered coordinates, blanking and sync outputs
module vga_timing_gen
   import vga_timing_pkg::*;
#(
   parameter int CLK_DIV         = DEF_CLK_DIV,
   parameter int H_VISIBLE       = DEF_H_VISIBLE,
   parameter int H_FRONT         = DEF_H_FRONT,
   parameter int H_SYNC          = DEF_H_SYNC,
   parameter int H_BACK          = DEF_H_BACK,
   parameter int V_VISIBLE       = DEF_V_VISIBLE,
   parameter int V_FRONT         = DEF_V_FRONT,
   parameter int V_SYNC          = DEF_V_SYNC,
   parameter int V_BACK          = DEF_V_BACK,
   parameter int SYNC_ACTIVE_LOW = 1
) (
   input  logic       clk,
   input  logic       rst,
   output logic       pix_en,
   output logic [9:0] col_addr,
   output logic [8:0] row_addr,
   output logic       rdn,
   output logic       hs,
   output logic       vs,
   output logic       frame_start
);

   localparam logic [9:0] H_LAST = 10'(H_VISIBLE + H_FRONT + H_SYNC + H_BACK - 1);
   localparam logic [9:0] V_LAST = 10'(V_VISIBLE + V_FRONT + V_SYNC + V_BACK - 1);
   localparam logic [9:0] H_VIS  = 10'(H_VISIBLE);
   localparam logic [9:0] V_VIS  = 10'(V_VISIBLE);
   localparam logic [9:0] HS_LO  = 10'(H_VISIBLE + H_FRONT);
   localparam logic [9:0] HS_HI  = 10'(H_VISIBLE + H_FRONT + H_SYNC);
   localparam logic [9:0] VS_LO  = 10'(V_VISIBLE + V_FRONT);
   localparam logic [9:0] VS_HI  = 10'(V_VISIBLE + V_FRONT + V_SYNC);
   localparam logic       SYNC_IDLE = (SYNC_ACTIVE_LOW != 0);

   logic [9:0] hcnt, vcnt;
   logic [9:0] h_nxt, v_nxt;
   logic       h_last, v_last;
   logic       h_vis_nxt, v_vis_nxt;

   pix_tick_gen #(.CLK_DIV(CLK_DIV)) u_tick (
      .clk    (clk),
      .rst    (rst),
      .pix_en (pix_en)
   );

   always_comb begin
      h_last    = (hcnt == H_LAST);
      v_last    = (vcnt == V_LAST);
      h_nxt     = h_last ? '0 : hcnt + 10'd1;
      v_nxt     = vcnt;
      if (h_last) begin
         v_nxt = v_last ? '0 : vcnt + 10'd1;
      end
      h_vis_nxt = (h_nxt < H_VIS);
      v_vis_nxt = (v_nxt < V_VIS);
   end

   assign frame_start = pix_en & h_last & v_last;

   // Outputs are decoded from the post-increment counts so they line up with the counters.
   always_ff @(posedge clk) begin
      if (rst) begin
         hcnt     <= '0;
         vcnt     <= '0;
         col_addr <= '0;
         row_addr <= '0;
         rdn      <= 1'b0;
         hs       <= SYNC_IDLE;
         vs       <= SYNC_IDLE;
      end else if (pix_en) begin
         hcnt     <= h_nxt;
         vcnt     <= v_nxt;
         col_addr <= h_vis_nxt ? h_nxt : COL_BLANK;
         row_addr <= v_vis_nxt ? v_nxt[8:0] : ROW_BLANK;
         rdn      <= ~(h_vis_nxt & v_vis_nxt);
         hs       <= in_window(h_nxt, HS_LO, HS_HI) ^ SYNC_IDLE;
         vs       <= in_window(v_nxt, VS_LO, VS_HI) ^ SYNC_IDLE;
      end
   end

endmodule

// File: tb/tb_vga_timing_gen.sv
// tb/tb_vga_timing_gen.sv - scoreboard bench for two vga_timing_gen configurations against an arithmetic raster model
module tb_vga_timing_gen;

   // dut0: CLK_DIV=4, full 800-pixel line, short frame; dut1: CLK_DIV=2, tiny raster, active-high syncs
   localparam int A_DIV = 4, A_HV = 640, A_HF = 16, A_HS = 96, A_HB = 48;
   localparam int A_VV = 4, A_VF = 1, A_VS = 2, A_VB = 2, A_AL = 1;
   localparam int B_DIV = 2, B_HV = 20, B_HF = 4, B_HS = 6, B_HB = 5;
   localparam int B_VV = 5, B_VF = 2, B_VS = 1, B_VB = 3, B_AL = 0;

   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   logic       pe0, fs0, rdn0, hs0, vs0, pe1, fs1, rdn1, hs1, vs1;
   logic [9:0] col0, col1;
   logic [8:0] row0, row1;

   vga_timing_gen #(
      .CLK_DIV(A_DIV), .H_VISIBLE(A_HV), .H_FRONT(A_HF), .H_SYNC(A_HS), .H_BACK(A_HB),
      .V_VISIBLE(A_VV), .V_FRONT(A_VF), .V_SYNC(A_VS), .V_BACK(A_VB), .SYNC_ACTIVE_LOW(A_AL)
   ) dut0 (
      .clk(clk), .rst(rst), .pix_en(pe0), .col_addr(col0), .row_addr(row0),
      .rdn(rdn0), .hs(hs0), .vs(vs0), .frame_start(fs0)
   );

   vga_timing_gen #(
      .CLK_DIV(B_DIV), .H_VISIBLE(B_HV), .H_FRONT(B_HF), .H_SYNC(B_HS), .H_BACK(B_HB),
      .V_VISIBLE(B_VV), .V_FRONT(B_VF), .V_SYNC(B_VS), .V_BACK(B_VB), .SYNC_ACTIVE_LOW(B_AL)
   ) dut1 (
      .clk(clk), .rst(rst), .pix_en(pe1), .col_addr(col1), .row_addr(row1),
      .rdn(rdn1), .hs(hs1), .vs(vs1), .frame_start(fs1)
   );

   typedef struct packed {
      logic       pe;
      logic       fs;
      logic [9:0] col;
      logic [8:0] row;
      logic       rdn;
      logic       hs;
      logic       vs;
   } obs_t;

   typedef struct {
      int   cyc;
      logic fs;
      obs_t after;
   } tick_t;

   tick_t q0[$];
   tick_t q1[$];
   int    n_chk = 0;
   int    n_pass = 0;
   int    k[2];
   bit    last_rst = 1'b1;

   task automatic check(input string name, input int d, input logic [31:0] act,
                        input logic [31:0] exp);
      n_chk++;
      if (act === exp) begin
         n_pass++;
      end else begin
         $display("FAIL %s dut%0d cyc=%0d: got %0h expected %0h", name, d, cyc, act, exp);
      end
   endtask

   function automatic obs_t get_obs(input int d);
      obs_t o;
      if (d == 0) o = {pe0, fs0, col0, row0, rdn0, hs0, vs0};
      else        o = {pe1, fs1, col1, row1, rdn1, hs1, vs1};
      return o;
   endfunction

   // Expected state k clocks after reset release, from raster arithmetic on the pixel count.
   function automatic obs_t model(input int d, input int kk);
      int dv, hv, hf, hsw, hb, vv, vf, vsw, vb, al, ht, vt, n, h, v;
      obs_t o;
      if (d == 0) begin
         dv = A_DIV; hv = A_HV; hf = A_HF; hsw = A_HS; hb = A_HB;
         vv = A_VV; vf = A_VF; vsw = A_VS; vb = A_VB; al = A_AL;
      end else begin
         dv = B_DIV; hv = B_HV; hf = B_HF; hsw = B_HS; hb = B_HB;
         vv = B_VV; vf = B_VF; vsw = B_VS; vb = B_VB; al = B_AL;
      end
      ht = hv + hf + hsw + hb;
      vt = vv + vf + vsw + vb;
      n  = kk / dv;
      h  = n % ht;
      v  = (n / ht) % vt;
      o.pe  = (kk % dv == dv - 1);
      o.fs  = o.pe && ((n + 1) % (ht * vt) == 0);
      o.col = (h < hv) ? 10'(h) : 10'd1023;
      o.row = (v < vv) ? 9'(v) : 9'd511;
      o.rdn = !((h < hv) && (v < vv));
      o.hs  = ((h >= hv + hf) && (h < hv + hf + hsw)) ^ (al != 0);
      o.vs  = ((v >= vv + vf) && (v < vv + vf + vsw)) ^ (al != 0);
      return o;
   endfunction

   function automatic bit can_rst();
      obs_t a, b;
      a = model(0, k[0]);
      b = model(1, k[1]);
      return !a.pe && !b.pe;
   endfunction

   task automatic step(input logic r);
      obs_t  o, e;
      tick_t t;
      @(negedge clk);
      if (last_rst) begin
         for (int d = 0; d < 2; d++) begin
            o = get_obs(d);
            check("rst_pix_en", d, 32'(o.pe), 32'd0);
            check("rst_frame_start", d, 32'(o.fs), 32'd0);
            check("rst_col", d, 32'(o.col), 32'd0);
            check("rst_row", d, 32'(o.row), 32'd0);
            check("rst_rdn", d, 32'(o.rdn), 32'd0);
            check("rst_hs", d, 32'(o.hs), (d == 0) ? 32'd1 : 32'd0);
            check("rst_vs", d, 32'(o.vs), (d == 0) ? 32'd1 : 32'd0);
         end
      end
      rst = r;
      last_rst = r;
      for (int d = 0; d < 2; d++) begin
         k[d] = r ? 0 : k[d] + 1;
         e = model(d, k[d]);
         if (e.pe) begin
            t.cyc   = cyc + 1;
            t.fs    = e.fs;
            t.after = model(d, k[d] + 1);
            if (d == 0) q0.push_back(t);
            else        q1.push_back(t);
         end
      end
   endtask

   // Monitor: each pix_en pops one scoreboard entry; the updated outputs are checked one clk later.
   bit    pend[2];
   obs_t  pend_exp[2];
   obs_t  mo;
   tick_t mt;
   int    qn;

   initial begin
      pend[0] = 1'b0;
      pend[1] = 1'b0;
      forever begin
         @(negedge clk);
         for (int d = 0; d < 2; d++) begin
            mo = get_obs(d);
            if (pend[d]) begin
               check("col_addr", d, 32'(mo.col), 32'(pend_exp[d].col));
               check("row_addr", d, 32'(mo.row), 32'(pend_exp[d].row));
               check("rdn", d, 32'(mo.rdn), 32'(pend_exp[d].rdn));
               check("hs", d, 32'(mo.hs), 32'(pend_exp[d].hs));
               check("vs", d, 32'(mo.vs), 32'(pend_exp[d].vs));
               pend[d] = 1'b0;
            end
            if (mo.pe === 1'b1) begin
               qn = (d == 0) ? q0.size() : q1.size();
               if (qn == 0) begin
                  check("spurious_pix_en", d, 32'(mo.pe), 32'd0);
               end else begin
                  mt = (d == 0) ? q0.pop_front() : q1.pop_front();
                  check("tick_cycle", d, 32'(cyc), 32'(mt.cyc));
                  check("frame_start", d, 32'(mo.fs), 32'(mt.fs));
                  pend[d]     = 1'b1;
                  pend_exp[d] = mt.after;
               end
            end else begin
               check("frame_start_idle", d, 32'(mo.fs), 32'd0);
            end
         end
      end
   end

   initial begin
      int  pos;
      bit  found;
      k[0] = 0;
      k[1] = 0;
      repeat (3) step(1'b1);

      // Whole short frame on dut0 (line timing, sync windows, frame wrap) and many dut1 frames.
      repeat (30000) step(1'b0);

      // One-clk reset at line 2, column 400 of dut0.
      found = 1'b0;
      for (int i = 0; i < 20000 && !found; i++) begin
         pos = (k[0] / A_DIV) % (800 * 9);
         if (pos == 2 * 800 + 400 && can_rst()) found = 1'b1;
         else step(1'b0);
      end
      check("mid_reset_reached", 0, 32'(found), 32'd1);
      step(1'b1);
      repeat (29500) step(1'b0);

      // Randomly placed short resets.
      for (int i = 0; i < 4000; i++) begin
         if (can_rst() && $urandom_range(0, 150) == 0) begin
            repeat ($urandom_range(1, 3)) step(1'b1);
         end else begin
            step(1'b0);
         end
      end
      repeat (10) step(1'b0);

      check("queue_drained", 0, 32'(q0.size()), 32'd0);
      check("queue_drained", 1, 32'(q1.size()), 32'd0);
      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
